throw_scheduler: RTL and testbench

THROW_SCHEDULER -- requirements
Module: throw_scheduler

---
 rtl/juggle_pkg.sv | 33 +++
 rtl/siteswap_checker.sv | 71 +++++++
 rtl/throw_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_throw_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/juggle_pkg.sv
// Shared definitions for the siteswap juggling scheduler.
package juggle_pkg;

   localparam int MAX_PERIOD = 7;
   localparam int BALL_W     = 3;
   localparam int HEIGHT_W   = 3;

   // Ball code marking an empty landing slot in the flight queue
   localparam logic [BALL_W-1:0] EMPTY_BALL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RUN   = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   // Slot (beat offset modulo period) where a throw of height h from position idx lands
   function automatic logic [2:0] landing_slot(input logic [2:0] idx,
                                               input logic [2:0] h,
                                               input logic [2:0] period);
      logic [3:0] pos;
      logic [3:0] rem;
      pos = {1'b0, idx} + {1'b0, h};
      if (period == 3'd0) begin
         rem = 4'd0;
      end else begin
         rem = pos % {1'b0, period};
      end
      return rem[2:0];
   endfunction

endpackage

// File: rtl/siteswap_checker.sv
// Validates a siteswap pattern one entry per cycle, then spends one finalize cycle
// on the average-height test. done/ok/num_balls are combinational so the caller
// can leave its check state on the very cycle the verdict is known.
module siteswap_checker
   import juggle_pkg::*;
#(
   parameter int MAX_PERIOD = juggle_pkg::MAX_PERIOD
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start,
   input  logic [2:0]                   period,
   input  logic [MAX_PERIOD-1:0][2:0]   pattern,
   output logic                         done,
   output logic                         ok,
   output logic [2:0]                   num_balls
);

   logic                  busy;
   logic [2:0]            idx;
   logic [5:0]            sum;
   logic [MAX_PERIOD-1:0] mask;
   logic [2:0]            h_cur;
   logic [2:0]            land;
   logic                  finalize;
   logic                  collide;
   logic [5:0]            quot;
   logic [5:0]            rem;

   // Current entry, its landing slot and the verdict for this cycle
   always_comb begin
      h_cur     = (idx < period) ? pattern[idx] : 3'd0;
      land      = landing_slot(idx, h_cur, period);
      finalize  = busy && (idx == period);
      collide   = busy && (idx != period) && mask[land];
      if (period == 3'd0) begin
         quot = 6'd0;
         rem  = 6'd1;
      end else begin
         quot = sum / {3'd0, period};
         rem  = sum % {3'd0, period};
      end
      done      = finalize || collide;
      ok        = finalize && (sum != 6'd0) && (rem == 6'd0);
      num_balls = quot[2:0];
   end

   // Walk the entries, accumulating the height sum and the landing-slot mask
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy <= 1'b0;
         idx  <= 3'd0;
         sum  <= 6'd0;
         mask <= '0;
      end else if (start) begin
         busy <= 1'b1;
         idx  <= 3'd0;
         sum  <= 6'd0;
         mask <= '0;
      end else if (busy) begin
         if (done) begin
            busy <= 1'b0;
         end else begin
            idx        <= idx + 3'd1;
            sum        <= sum + {3'd0, h_cur};
            mask[land] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/throw_scheduler.sv
// Siteswap throw scheduler: validates a loaded pattern, then on every beat pops the
// ball due to land now and re-inserts it h beats ahead, reporting each throw.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no pattern running, waiting for a load
//   CHECK    | siteswap checker walking the pattern (period+1 cycles max)
//   RUN      | pattern valid, throwing on each beat
//   ERROR    | invalid pattern or schedule conflict, waiting for a load
module throw_scheduler
   import juggle_pkg::*;
#(
   parameter int MAX_PERIOD = juggle_pkg::MAX_PERIOD
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        nf_in,
   input  logic [MAX_PERIOD-1:0][2:0]  pattern_in,
   input  logic [2:0]                  period_in,
   input  logic [14:0]                 frame_per_beat_in,
   input  logic                        load_in,
   output logic                        load_ready_out,
   input  logic                        stop_in,
   output logic                        pattern_ok_out,
   output logic                        pattern_err_out,
   output logic [2:0]                  num_balls_out,
   output logic                        throw_valid_out,
   output logic [2:0]                  throw_ball_out,
   output logic                        throw_hand_out,
   output logic [2:0]                  throw_height_out
);

   state_t                        state;
   state_t                        state_nxt;

   logic [MAX_PERIOD-1:0][2:0]    pat_q;
   logic [2:0]                    period_q;
   logic [14:0]                   fpb_q;

   logic [MAX_PERIOD-1:0][2:0]    queue;
   logic [MAX_PERIOD-1:0][2:0]    queue_shift;
   logic [MAX_PERIOD-1:0][2:0]    queue_beat;
   logic [2:0]                    pidx;
   logic                          hand;
   logic [14:0]                   frame_cnt;

   logic                          load_fire;
   logic                          chk_start;
   logic                          chk_done;
   logic                          chk_ok;
   logic [2:0]                    chk_num_balls;

   logic [2:0]                    beat_ball;
   logic [2:0]                    beat_h;
   logic                          slot_busy;
   logic                          conflict;
   logic                          beat;
   logic                          beat_ok;
   logic                          beat_bad;

   assign load_fire = load_in && load_ready_out;
   assign chk_start = load_fire && (period_in != 3'd0);

   siteswap_checker #(
      .MAX_PERIOD (MAX_PERIOD)
   ) u_checker (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .start     (chk_start),
      .period    (period_q),
      .pattern   (pat_q),
      .done      (chk_done),
      .ok        (chk_ok),
      .num_balls (chk_num_balls)
   );

   // Queue after one beat and whether that beat breaks the schedule
   always_comb begin
      beat_ball = queue[0];
      beat_h    = pat_q[pidx];
      for (int k = 0; k < MAX_PERIOD - 1; k++) begin
         queue_shift[k] = queue[k+1];
      end
      queue_shift[MAX_PERIOD-1] = EMPTY_BALL;
      queue_beat = queue_shift;
      slot_busy  = 1'b0;
      if (beat_h != 3'd0) begin
         slot_busy                  = (queue_shift[beat_h - 3'd1] != EMPTY_BALL);
         queue_beat[beat_h - 3'd1]  = beat_ball;
      end
      conflict = ((beat_ball == EMPTY_BALL) && (beat_h != 3'd0)) ||
                 ((beat_ball != EMPTY_BALL) && (beat_h == 3'd0)) ||
                 slot_busy;
      // load and stop both pre-empt a coincident beat
      beat     = (state == ST_RUN) && nf_in && (frame_cnt == 15'd0) && !load_fire && !stop_in;
      beat_ok  = beat && !conflict;
      beat_bad = beat && conflict;
   end

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; a load always wins, including over stop in RUN
   always_comb begin
      state_nxt = state;
      if (load_fire) begin
         state_nxt = (period_in == 3'd0) ? ST_ERROR : ST_CHECK;
      end else begin
         case (state)
            ST_CHECK: begin
               if (chk_done) begin
                  state_nxt = chk_ok ? ST_RUN : ST_ERROR;
               end
            end
            ST_RUN: begin
               if (stop_in) begin
                  state_nxt = ST_IDLE;
               end else if (beat_bad) begin
                  state_nxt = ST_ERROR;
               end
            end
            ST_IDLE, ST_ERROR: state_nxt = state;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      load_ready_out  = (state != ST_CHECK);
      pattern_err_out = (state == ST_ERROR);
   end

   // Pattern latch, status, flight queue, beat counters and throw event register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pat_q            <= '0;
         period_q         <= 3'd0;
         fpb_q            <= 15'd0;
         pattern_ok_out   <= 1'b0;
         num_balls_out    <= 3'd0;
         queue            <= {MAX_PERIOD{EMPTY_BALL}};
         pidx             <= 3'd0;
         hand             <= 1'b0;
         frame_cnt        <= 15'd0;
         throw_valid_out  <= 1'b0;
         throw_ball_out   <= 3'd0;
         throw_hand_out   <= 1'b0;
         throw_height_out <= 3'd0;
      end else begin
         throw_valid_out  <= 1'b0;
         throw_ball_out   <= 3'd0;
         throw_hand_out   <= 1'b0;
         throw_height_out <= 3'd0;
         if (load_fire) begin
            pat_q          <= pattern_in;
            period_q       <= period_in;
            fpb_q          <= (frame_per_beat_in == 15'd0) ? 15'd1 : frame_per_beat_in;
            pattern_ok_out <= 1'b0;
            num_balls_out  <= 3'd0;
         end else if ((state == ST_CHECK) && chk_done && chk_ok) begin
            pattern_ok_out <= 1'b1;
            num_balls_out  <= chk_num_balls;
            for (int k = 0; k < MAX_PERIOD; k++) begin
               queue[k] <= (k < int'(chk_num_balls)) ? 3'(k) : EMPTY_BALL;
            end
            pidx      <= 3'd0;
            hand      <= 1'b0;
            frame_cnt <= 15'd0;
         end else if ((state == ST_RUN) && !stop_in && nf_in) begin
            frame_cnt <= ((frame_cnt + 15'd1) == fpb_q) ? 15'd0 : frame_cnt + 15'd1;
            if (beat_bad) begin
               pattern_ok_out <= 1'b0;
            end else if (beat_ok) begin
               queue <= queue_beat;
               pidx  <= ((pidx + 3'd1) == period_q) ? 3'd0 : pidx + 3'd1;
               hand  <= ~hand;
               if (beat_ball != EMPTY_BALL) begin
                  throw_valid_out  <= 1'b1;
                  throw_ball_out   <= beat_ball;
                  throw_hand_out   <= hand;
                  throw_height_out <= beat_h;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_throw_scheduler.sv
// Directed bench for throw_scheduler with a queue-level juggling model.
module tb_throw_scheduler;

   localparam int M_IDLE  = 0;
   localparam int M_CHECK = 1;
   localparam int M_RUN   = 2;
   localparam int M_ERROR = 3;
   localparam int EMPTY   = 7;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic             nf_in = 1'b0;
   logic [6:0][2:0]  pattern_in = '0;
   logic [2:0]       period_in = 3'd0;
   logic [14:0]      frame_per_beat_in = 15'd0;
   logic             load_in = 1'b0;
   logic             load_ready_out;
   logic             stop_in = 1'b0;
   logic             pattern_ok_out;
   logic             pattern_err_out;
   logic [2:0]       num_balls_out;
   logic             throw_valid_out;
   logic [2:0]       throw_ball_out;
   logic             throw_hand_out;
   logic [2:0]       throw_height_out;

   int checks = 0;
   int errors = 0;

   throw_scheduler dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .nf_in             (nf_in),
      .pattern_in        (pattern_in),
      .period_in         (period_in),
      .frame_per_beat_in (frame_per_beat_in),
      .load_in           (load_in),
      .load_ready_out    (load_ready_out),
      .stop_in           (stop_in),
      .pattern_ok_out    (pattern_ok_out),
      .pattern_err_out   (pattern_err_out),
      .num_balls_out     (num_balls_out),
      .throw_valid_out   (throw_valid_out),
      .throw_ball_out    (throw_ball_out),
      .throw_hand_out    (throw_hand_out),
      .throw_height_out  (throw_height_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode = M_IDLE;
   int m_ok = 0, m_nb = 0;
   int m_valid = 0, m_ball = 0, m_hand = 0, m_height = 0;
   int m_pat[7];
   int m_per = 0, m_fpb = 1;
   int m_q[7];
   int m_sh[7];
   int m_pidx = 0, m_side = 0, m_fc = 0;
   int m_cnt = 0, m_good = 0, m_calc_nb = 0;
   int m_sum, m_fail, m_b, m_h, m_bad;
   int m_used[7];

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_mode = M_IDLE; m_ok = 0; m_nb = 0;
         m_valid = 0; m_ball = 0; m_hand = 0; m_height = 0;
         m_pidx = 0; m_side = 0; m_fc = 0; m_cnt = 0;
         for (int k = 0; k < 7; k++) m_q[k] = EMPTY;
      end else begin
         m_valid = 0; m_ball = 0; m_hand = 0; m_height = 0;
         if (load_in && m_mode != M_CHECK) begin
            for (int k = 0; k < 7; k++) m_pat[k] = int'(pattern_in[k]);
            m_per = int'(period_in);
            m_fpb = (frame_per_beat_in == 0) ? 1 : int'(frame_per_beat_in);
            m_ok = 0; m_nb = 0;
            if (m_per == 0) begin
               m_mode = M_ERROR;
            end else begin
               m_sum = 0; m_fail = -1;
               for (int k = 0; k < 7; k++) m_used[k] = 0;
               for (int i = 0; i < m_per; i++) begin
                  if (m_fail < 0 && m_used[(i + m_pat[i]) % m_per] != 0) m_fail = i;
                  m_used[(i + m_pat[i]) % m_per] = 1;
                  m_sum += m_pat[i];
               end
               if (m_fail >= 0) begin
                  m_cnt = m_fail + 1; m_good = 0;
               end else begin
                  m_cnt = m_per + 1;
                  m_good = (m_sum % m_per == 0) && (m_sum != 0);
               end
               m_calc_nb = m_sum / m_per;
               m_mode = M_CHECK;
            end
         end else if (m_mode == M_CHECK) begin
            m_cnt--;
            if (m_cnt == 0) begin
               if (m_good != 0) begin
                  m_mode = M_RUN; m_ok = 1; m_nb = m_calc_nb;
                  for (int k = 0; k < 7; k++) m_q[k] = (k < m_nb) ? k : EMPTY;
                  m_pidx = 0; m_side = 0; m_fc = 0;
               end else begin
                  m_mode = M_ERROR;
               end
            end
         end else if (m_mode == M_RUN) begin
            if (stop_in) begin
               m_mode = M_IDLE;
            end else if (nf_in) begin
               if (m_fc == 0) begin
                  m_b = m_q[0];
                  m_h = m_pat[m_pidx];
                  for (int k = 0; k < 6; k++) m_sh[k] = m_q[k+1];
                  m_sh[6] = EMPTY;
                  m_bad = (m_b == EMPTY && m_h > 0) || (m_b != EMPTY && m_h == 0) ||
                          (m_h > 0 && m_sh[m_h > 0 ? m_h - 1 : 0] != EMPTY);
                  if (m_bad != 0) begin
                     m_mode = M_ERROR; m_ok = 0;
                  end else begin
                     if (m_h > 0) m_sh[m_h - 1] = m_b;
                     for (int k = 0; k < 7; k++) m_q[k] = m_sh[k];
                     if (m_b != EMPTY) begin
                        m_valid = 1; m_ball = m_b; m_hand = m_side; m_height = m_h;
                     end
                     m_pidx = (m_pidx + 1) % m_per;
                     m_side = 1 - m_side;
                  end
               end
               m_fc = (m_fc + 1) % m_fpb;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk_in) begin
      if (!rst_in) begin
         check("load_ready", int'(load_ready_out), (m_mode != M_CHECK) ? 1 : 0);
         check("pattern_err", int'(pattern_err_out), (m_mode == M_ERROR) ? 1 : 0);
         check("pattern_ok", int'(pattern_ok_out), m_ok);
         check("num_balls", int'(num_balls_out), m_nb);
         check("throw_valid", int'(throw_valid_out), m_valid);
         check("throw_ball", int'(throw_ball_out), m_ball);
         check("throw_hand", int'(throw_hand_out), m_hand);
         check("throw_height", int'(throw_height_out), m_height);
      end
   end

   // Event log for the literal sequence checks
   typedef struct {
      int ball;
      int hand;
      int height;
   } ev_t;
   ev_t ev_q[$];

   always @(negedge clk_in) begin
      if (!rst_in && throw_valid_out) begin
         ev_q.push_back('{int'(throw_ball_out), int'(throw_hand_out), int'(throw_height_out)});
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic frame();
      nf_in = 1'b1;
      tick();
      nf_in = 1'b0;
      tick();
   endtask

   task automatic do_load(input int per, input int fpb, input int h0, input int h1,
                          input int h2, input logic with_stop);
      int hs[3];
      hs = '{h0, h1, h2};
      for (int k = 0; k < 7; k++) begin
         pattern_in[k] = (k < per && k < 3) ? 3'(hs[k]) : 3'd6;
      end
      period_in         = 3'(per);
      frame_per_beat_in = 15'(fpb);
      load_in           = 1'b1;
      stop_in           = with_stop;
      tick();
      load_in = 1'b0;
      stop_in = 1'b0;
   endtask

   task automatic check_ev(input string tag, input int i, input int b, input int hd, input int ht);
      if (ev_q.size() <= i) begin
         checks++;
         errors++;
         $display("FAIL %s event %0d: missing, got %0d events, expected more", tag, i, ev_q.size());
      end else begin
         check($sformatf("%s ev%0d ball", tag, i), ev_q[i].ball, b);
         check($sformatf("%s ev%0d hand", tag, i), ev_q[i].hand, hd);
         check($sformatf("%s ev%0d height", tag, i), ev_q[i].height, ht);
      end
   endtask

   initial begin
      int exp_b[7];
      int exp_h[7];
      tick();
      tick();
      rst_in = 1'b0;
      tick();
      check("reset ready", int'(load_ready_out), 1);
      check("reset ok", int'(pattern_ok_out), 0);
      check("reset err", int'(pattern_err_out), 0);
      check("reset valid", int'(throw_valid_out), 0);

      // "3", period 1, four frames per beat
      do_load(1, 4, 3, 0, 0, 1'b0);
      check("p3 ok@0", int'(pattern_ok_out), 0);
      tick();
      check("p3 ok@1", int'(pattern_ok_out), 0);
      tick();
      check("p3 ok@2", int'(pattern_ok_out), 1);
      check("p3 num_balls", int'(num_balls_out), 3);
      ev_q.delete();
      repeat (16) frame();
      check("p3 event count", ev_q.size(), 4);
      check_ev("p3", 0, 0, 0, 3);
      check_ev("p3", 1, 1, 1, 3);
      check_ev("p3", 2, 2, 0, 3);
      check_ev("p3", 3, 0, 1, 3);

      // "531", one frame per beat
      do_load(3, 1, 5, 3, 1, 1'b0);
      repeat (4) tick();
      check("p531 ok", int'(pattern_ok_out), 1);
      check("p531 num_balls", int'(num_balls_out), 3);
      ev_q.delete();
      repeat (7) frame();
      exp_b = '{0, 1, 2, 2, 1, 0, 0};
      exp_h = '{5, 3, 1, 5, 3, 1, 5};
      check("p531 event count", ev_q.size(), 7);
      for (int i = 0; i < 7; i++) check_ev("p531", i, exp_b[i], i % 2, exp_h[i]);

      // "543": collision on entry 1
      do_load(3, 1, 5, 4, 3, 1'b0);
      check("p543 err@0", int'(pattern_err_out), 0);
      tick();
      check("p543 err@1", int'(pattern_err_out), 0);
      tick();
      check("p543 err@2", int'(pattern_err_out), 1);
      check("p543 ok", int'(pattern_ok_out), 0);

      // "54": rejected
      do_load(2, 1, 5, 4, 0, 1'b0);
      tick();
      tick();
      check("p54 err", int'(pattern_err_out), 1);

      // period 0: error on the next cycle
      do_load(0, 1, 3, 0, 0, 1'b0);
      check("p0 err", int'(pattern_err_out), 1);
      check("p0 ready", int'(load_ready_out), 1);

      // "51": valid, but beat 1 is a schedule conflict
      do_load(2, 1, 5, 1, 0, 1'b0);
      repeat (3) tick();
      check("p51 ok", int'(pattern_ok_out), 1);
      check("p51 num_balls", int'(num_balls_out), 3);
      ev_q.delete();
      repeat (4) frame();
      check("p51 event count", ev_q.size(), 1);
      check_ev("p51", 0, 0, 0, 5);
      check("p51 err", int'(pattern_err_out), 1);

      // "3" running, then stop and load together
      do_load(1, 4, 3, 0, 0, 1'b0);
      repeat (2) tick();
      repeat (2) frame();
      do_load(1, 4, 3, 0, 0, 1'b1);
      check("stop+load ready", int'(load_ready_out), 0);
      repeat (2) tick();
      check("stop+load ok", int'(pattern_ok_out), 1);

      // plain stop returns to IDLE
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      check("stop ready", int'(load_ready_out), 1);
      check("stop err", int'(pattern_err_out), 0);

      // reset in the middle of RUN, while a throw event is showing
      do_load(1, 4, 3, 0, 0, 1'b0);
      repeat (2) tick();
      nf_in = 1'b1;
      tick();
      nf_in = 1'b0;
      check("pre-reset valid", int'(throw_valid_out), 1);
      rst_in = 1'b1;
      #1;
      check("rst valid", int'(throw_valid_out), 0);
      check("rst ok", int'(pattern_ok_out), 0);
      check("rst num_balls", int'(num_balls_out), 0);
      check("rst ready", int'(load_ready_out), 1);
      check("rst ball", int'(throw_ball_out), 0);
      tick();
      tick();
      rst_in = 1'b0;
      tick();

      // frame_per_beat 0 behaves as 1
      do_load(1, 0, 3, 0, 0, 1'b0);
      repeat (2) tick();
      ev_q.delete();
      repeat (5) frame();
      check("fpb0 event count", ev_q.size(), 5);
      check_ev("fpb0", 0, 0, 0, 3);
      check_ev("fpb0", 3, 0, 1, 3);
      check_ev("fpb0", 4, 1, 0, 3);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
